// File: rtl/aes_pkg.sv
// Shared AES-128 types and constants for the decryption datapath stages.
package aes_pkg;

  // Number of AES-128 rounds and key length in 32-bit words.
  localparam int AES_NR       = 10;
  localparam int AES_NK_WORDS = 4;

  // 128-bit state word: bit 127 is byte 0 (row 0, column 0).
  typedef logic [127:0] state_t;

  // Round / round-key index, wide enough for 0..AES_NR.
  typedef logic [3:0]   round_idx_t;

  // AddRoundKey is its own inverse: a plain XOR of state and round key.
  function automatic state_t add_round_key(input state_t s, input state_t k);
    return s ^ k;
  endfunction

endpackage

// File: rtl/inv_add_round_key_if.sv
// Streaming handshake bundle around the inverse AddRoundKey stage:
// an upstream state channel and a downstream result channel.
interface inv_add_round_key_if;
  import aes_pkg::*;

  // Upstream state channel
  logic       in_valid;
  logic       in_ready;
  state_t     in_state;

  // Downstream result channel
  logic       out_valid;
  logic       out_ready;
  state_t     out_state;
  round_idx_t out_round;
  logic       out_last;

  // Stage view: consumes the input channel, produces the output channel.
  modport slave (
    input  in_valid,
    input  in_state,
    output in_ready,
    output out_valid,
    output out_state,
    output out_round,
    output out_last,
    input  out_ready
  );

  // Neighbour view: produces input states and consumes results.
  modport master (
    output in_valid,
    output in_state,
    input  in_ready,
    input  out_valid,
    input  out_state,
    input  out_round,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/round_key_store.sv
// Register file holding the NR+1 expanded round keys, with one write port,
// one asynchronous read port and a per-index written flag.
module round_key_store
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,      // already qualified: index in range, between blocks
  input  round_idx_t waddr,
  input  state_t     wdata,
  input  round_idx_t raddr,
  output state_t     rdata,
  output logic       loaded
);

  state_t        mem [NR+1];
  logic [NR:0]   written;

  // Key storage write; contents survive reset and are gated by the flags.
  // NOTE: the key array has no reset on purpose -- it is a plain register file
  // and the written flags below are what make stale contents unusable.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Track which indices have been written since reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      written <= '0;
    end else if (we) begin
      written[waddr] <= 1'b1;
    end
  end

  // Read-before-write falls out naturally: a same-cycle write only lands at the
  // clock edge, so the reader still sees the old key this cycle.
  assign rdata  = mem[raddr];
  assign loaded = &written;

endmodule

// File: rtl/inv_add_round_key.sv
// AES-128 decryption AddRoundKey stage: walks the round keys from rk[NR] down
// to rk[0] for each block, XORs every accepted state with the current key and
// presents it through a single output register with valid/ready handshake.
module inv_add_round_key
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_we,
  input  round_idx_t key_idx,
  input  state_t     key_data,
  output logic       key_loaded,
  input  logic       abort,
  inv_add_round_key_if.slave bus
);

  localparam round_idx_t LAST_ROUND = round_idx_t'(NR);

  round_idx_t rnd;        // round whose key the next accepted state uses
  state_t     rk;         // current round key
  logic       accept;
  logic       key_write;

  // Keys may only change between blocks so a block never mixes two schedules.
  assign key_write = key_we && (rnd == LAST_ROUND) && (key_idx <= LAST_ROUND);

  round_key_store #(
    .NR (NR)
  ) u_keys (
    .clk    (clk),
    .reset  (reset),
    .we     (key_write),
    .waddr  (key_idx),
    .wdata  (key_data),
    .raddr  (rnd),
    .rdata  (rk),
    .loaded (key_loaded)
  );

  // Single output register with no skid buffer: accept only when the register
  // is empty or being drained this cycle.
  assign bus.in_ready = key_loaded && (!bus.out_valid || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  // Round counter, output register and handshake state.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rnd           <= LAST_ROUND;
      bus.out_valid <= 1'b0;
      bus.out_state <= '0;
      bus.out_round <= '0;
      bus.out_last  <= 1'b0;
    end else if (abort) begin
      // Drop the block in flight; a same-cycle accept is discarded.
      rnd           <= LAST_ROUND;
      bus.out_valid <= 1'b0;
    end else if (accept) begin
      bus.out_state <= add_round_key(bus.in_state, rk);
      bus.out_round <= rnd;
      bus.out_last  <= (rnd == '0);
      bus.out_valid <= 1'b1;
      rnd           <= (rnd == '0) ? LAST_ROUND : rnd - 1'b1;
    end else if (bus.out_ready) begin
      // Drained with nothing new behind it; data registers keep their values.
      bus.out_valid <= 1'b0;
    end
  end

  // A stalled output must hold its contents until it is taken or aborted.
  a_hold_under_backpressure : assert property (
    @(posedge clk) disable iff (reset)
    (bus.out_valid && !bus.out_ready && !abort) |=>
      (bus.out_valid && $stable(bus.out_state) &&
       $stable(bus.out_round) && $stable(bus.out_last))
  );

  // The round counter never leaves 0..NR.
  a_rnd_in_range : assert property (
    @(posedge clk) disable iff (reset)
    rnd <= LAST_ROUND
  );

endmodule
